seg7_mux_counter: RTL and testbench
===================================

SEG7_MUX_COUNTER -- requirements
Module: seg7_mux_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 10: prescaler period in clk cycles per count step (legal >= 2).
REQ-002 SHALL have parameter DIGITS, default 2: number of BCD digits counted and displayed (legal 1..4).
REQ-003 SHALL have parameter SCAN_DIV, default 4: clk cycles each digit stays selected (legal >= 1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1  count enable; gates the prescaler.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-010 SHALL have port segments  output  7  active-high segment pattern of the selected digit, bit0 = a ... bit6 = g.
REQ-011 SHALL have port digit_sel  output  DIGITS  one-hot, active-high digit select.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on count roll-over.

Function
REQ-013 Prescaler SHALL count 0..MAX_COUNT-1 only while en=1 and hold its value while en=0.
REQ-014 A tick SHALL occur on the edge where en=1 and prescaler = MAX_COUNT-1; prescaler returns to 0 on that edge.
REQ-015 On a tick with up=1 the count SHALL increment in BCD with carry between digits; all-9s wraps to all-0s.
REQ-016 On a tick with up=0 the count SHALL decrement in BCD with borrow; all-0s wraps to all-9s.
REQ-017 wrap SHALL be 1 for exactly the cycle following a wrapping tick, 0 otherwise; registered output.
REQ-018 load=1 SHALL set the count to load_val and clear the prescaler on that edge, taking priority over a coincident tick; no wrap pulse on load.
REQ-019 Any load_val nibble > 9 SHALL load as 0 in that digit; other digits load unaffected.
REQ-020 Scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of en; at SCAN_DIV-1 the digit index advances 0..DIGITS-1 and wraps to 0.
REQ-021 digit_sel and segments SHALL be registered and change on the same edge, segments showing the count digit addressed by the new digit index (one-cycle latency from count change).
REQ-022 Decode SHALL be 0..9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-023 With DIGITS=1, digit_sel SHALL be constant 1 and the scan counter has no effect.

Reset
REQ-024 While rst=1 at an edge: prescaler, count, scan counter, digit index SHALL clear to 0; digit_sel = 1 (digit 0); segments = 7'h3F; wrap = 0.
REQ-025 rst SHALL override load, en and any pending tick; reset mid-count discards partial prescale.

Configuration
REQ-026 Macro SEG7_LEADING_ZERO_BLANK_EN defined: segments SHALL be 7'h00 for any digit i > 0 where digit i and all higher digits are 0; digit 0 never blanked.
REQ-027 Macro undefined: every digit SHALL show its decode, including leading zeros (7'h3F).

Structure
REQ-028 Package seg7_pkg SHALL hold typedefs bcd_t (4 bits) and seg_t (7 bits) and the ten-entry segment pattern constant table plus SEG_BLANK.
REQ-029 Sub-module seg7_decoder (combinational bcd_t -> seg_t, out-of-range -> SEG_BLANK) SHALL be the only decode instance; all state stays in seg7_mux_counter.

Verification
REQ-030 Reset: rst=1 for 2 cycles -> segments=7'h3F, digit_sel=2'b01, wrap=0 (DIGITS=2).
REQ-031 Up count: en=1, up=1 from reset -> count 01 after 10 cycles, 99 after 990, 00 after 1000 with wrap=1 for exactly one cycle.
REQ-032 Down wrap: reset, en=1, up=0 -> after 10 cycles count=99, wrap pulses once.
REQ-033 Load priority: load=1, load_val=8'h42 on the tick edge -> count=42, no wrap, next change to 43 exactly 10 cycles later; load_val=8'hA5 -> count=05.
REQ-034 Enable hold: en=0 for 5 cycles mid-prescale -> count frozen, next tick delayed by exactly 5 cycles.
REQ-035 Scan/blank: count=05, SCAN_DIV=4 -> digit_sel alternates 01/10 every 4 cycles; digit 1 segments = 7'h00 with SEG7_LEADING_ZERO_BLANK_EN, 7'h3F without; digit 0 = 7'h6D.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment counter.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high patterns for BCD 0..9, bit0 = a ... bit6 = g.
  localparam seg_t SEG_TABLE [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a blank digit.
module seg7_decoder
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Table lookup for legal digits, blank for anything else.
  always_comb begin
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_mux_counter.sv
// Prescaled up/down BCD counter with a time-multiplexed seven-segment display.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_mux_counter
  import seg7_pkg::*;
#(
  parameter int MAX_COUNT = 10,
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  wrap
);

  localparam int PW = $clog2(MAX_COUNT);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = 4 * DIGITS;

  logic [PW-1:0]     presc_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic [CW-1:0]     load_clean_s;
  logic              roll_s;
  logic              tick_s;
  logic [SW-1:0]     scan_r;
  logic [SW-1:0]     scan_nxt_s;
  logic [1:0]        idx_r;
  logic [1:0]        idx_nxt_s;
  bcd_t              sel_digit_s;
  seg_t              dec_s;
  seg_t              seg_nxt_s;
  logic [DIGITS-1:0] digit_sel_r;
  seg_t              segments_r;
  logic              wrap_r;

  assign tick_s    = en && (presc_r == PW'(MAX_COUNT - 1));
  assign segments  = segments_r;
  assign digit_sel = digit_sel_r;
  assign wrap      = wrap_r;

  // Next BCD count with ripple carry/borrow; roll_s survives only when every digit rolled.
  always_comb begin
    count_nxt_s  = count_r;
    load_clean_s = {CW{1'b0}};
    roll_s       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clean_s[4*i +: 4] = 4'd0;
      end else begin
        load_clean_s[4*i +: 4] = load_val[4*i +: 4];
      end
      if (!roll_s) begin
        count_nxt_s[4*i +: 4] = count_r[4*i +: 4];
      end else if (up) begin
        if (count_r[4*i +: 4] == 4'd9) begin
          count_nxt_s[4*i +: 4] = 4'd0;
        end else begin
          count_nxt_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
          roll_s                = 1'b0;
        end
      end else begin
        if (count_r[4*i +: 4] == 4'd0) begin
          count_nxt_s[4*i +: 4] = 4'd9;
        end else begin
          count_nxt_s[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
          roll_s                = 1'b0;
        end
      end
    end
  end

  // Scan divider and digit index advance.
  always_comb begin
    if (scan_r == SW'(SCAN_DIV - 1)) begin
      scan_nxt_s = {SW{1'b0}};
      if (idx_r == 2'(DIGITS - 1)) begin
        idx_nxt_s = 2'd0;
      end else begin
        idx_nxt_s = idx_r + 2'd1;
      end
    end else begin
      scan_nxt_s = scan_r + SW'(1);
      idx_nxt_s  = idx_r;
    end
  end

  // Pick the count digit the display will point at after this edge.
  always_comb begin
    sel_digit_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt_s == 2'(i)) begin
        sel_digit_s = count_r[4*i +: 4];
      end else begin
        sel_digit_s = sel_digit_s;
      end
    end
  end

  seg7_decoder u_dec (
    .bcd (sel_digit_s),
    .seg (dec_s)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic hi_zero_s;
  logic blank_s;

  // A digit above 0 is blanked when it and every higher digit are zero.
  always_comb begin
    hi_zero_s = 1'b1;
    blank_s   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero_s = hi_zero_s && (count_r[4*i +: 4] == 4'd0);
      if ((i != 0) && (idx_nxt_s == 2'(i))) begin
        blank_s = hi_zero_s;
      end else begin
        blank_s = blank_s;
      end
    end
    if (blank_s) begin
      seg_nxt_s = SEG_BLANK;
    end else begin
      seg_nxt_s = dec_s;
    end
  end
`else
  assign seg_nxt_s = dec_s;
`endif

  // Prescaler, count and wrap pulse; load beats a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      wrap_r  <= 1'b0;
    end else if (load) begin
      presc_r <= {PW{1'b0}};
      count_r <= load_clean_s;
      wrap_r  <= 1'b0;
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
      count_r <= count_nxt_s;
      wrap_r  <= roll_s;
    end else begin
      if (en) begin
        presc_r <= presc_r + PW'(1);
      end else begin
        presc_r <= presc_r;
      end
      wrap_r <= 1'b0;
    end
  end

  // Display scan: select and segments move together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r      <= {SW{1'b0}};
      idx_r       <= 2'd0;
      digit_sel_r <= DIGITS'(1'b1);
      segments_r  <= 7'h3F;
    end else begin
      scan_r      <= scan_nxt_s;
      idx_r       <= idx_nxt_s;
      digit_sel_r <= DIGITS'(1'b1) << idx_nxt_s;
      segments_r  <= seg_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Directed self-checking bench for seg7_mux_counter with default parameters.
module tb_seg7_mux_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [6:0] segments;
  logic [1:0] digit_sel;
  logic       wrap;

  int   checks   = 0;
  int   errors   = 0;
  int   wrap_cnt = 0;
  logic last_wrap;
  logic [1:0] ds [16];
  logic [6:0] sg [16];
  int   k;

  localparam logic [6:0] PAT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  always #5 clk = ~clk;

  seg7_mux_counter #(
    .MAX_COUNT (10),
    .DIGITS    (2),
    .SCAN_DIV  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .segments  (segments),
    .digit_sel (digit_sel),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: cross the active edge, sample at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    last_wrap = wrap;
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic run_en(input int n);
    en = 1'b1;
    repeat (n) step();
    en = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    repeat (2) step();
    rst      = 1'b0;
    wrap_cnt = 0;
  endtask

  // Count is frozen (en=0) while both scanned digits are captured.
  task automatic read_expect(input string tag, input int v);
    logic [6:0] s0, s1;
    bit g0, g1;
    g0 = 1'b0;
    g1 = 1'b0;
    s0 = 7'h00;
    s1 = 7'h00;
    for (int i = 0; i < 16 && !(g0 && g1); i++) begin
      step();
      if (digit_sel == 2'b01) begin
        s0 = segments;
        g0 = 1'b1;
      end else if (digit_sel == 2'b10) begin
        s1 = segments;
        g1 = 1'b1;
      end
    end
    if (!(g0 && g1)) begin
      check({tag, "_scan_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_d0"}, s0, PAT[v % 10]);
      check({tag, "_d1"}, s1, (BLANK && (v / 10 == 0)) ? 7'h00 : PAT[v / 10]);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    @(negedge clk);
    repeat (2) step();
    check("rst_seg", segments, 7'h3F);
    check("rst_sel", digit_sel, 2'b01);
    check("rst_wrap", wrap, 1'b0);
    rst = 1'b0;
    wrap_cnt = 0;

    // Up count through the full range and roll-over.
    up = 1'b1;
    run_en(10);
    read_expect("up01", 1);
    check("up01_nowrap", wrap_cnt, 0);
    run_en(980);
    read_expect("up99", 99);
    check("up99_nowrap", wrap_cnt, 0);
    run_en(10);
    check("up_wrap_edge", last_wrap, 1'b1);
    read_expect("up00", 0);
    check("up_wrap_once", wrap_cnt, 1);

    // Down count wraps from 00 to 99.
    do_reset();
    up = 1'b0;
    run_en(10);
    check("dn_wrap_edge", last_wrap, 1'b1);
    read_expect("dn99", 99);
    check("dn_wrap_once", wrap_cnt, 1);

    // Load on a tick edge that would otherwise wrap downward.
    do_reset();
    up = 1'b0;
    run_en(9);
    load = 1'b1; load_val = 8'h42; en = 1'b1;
    step();
    load = 1'b0; en = 1'b0;
    check("load_nowrap", last_wrap, 1'b0);
    up = 1'b1;
    run_en(9);
    read_expect("ld42", 42);
    run_en(1);
    read_expect("ld43", 43);
    check("load_wrap_none", wrap_cnt, 0);

    load = 1'b1; load_val = 8'hF3;
    step();
    load = 1'b0;
    read_expect("ldF3", 3);
    load = 1'b1; load_val = 8'hA5;
    step();
    load = 1'b0;
    read_expect("ldA5", 5);

    // Scan pattern with count 05 frozen.
    for (int i = 0; i < 16; i++) begin
      step();
      ds[i] = digit_sel;
      sg[i] = segments;
    end
    k = 0;
    for (int i = 1; i <= 4; i++) begin
      if (k == 0 && ds[i] != ds[i-1]) k = i;
    end
    check("scan_edge_found", (k != 0), 1'b1);
    check("scan_onehot", (ds[k] == 2'b01 || ds[k] == 2'b10), 1'b1);
    for (int j = 0; j < 8; j++) begin
      check("scan_sel", ds[k+j], (j < 4) ? ds[k] : (ds[k] ^ 2'b11));
    end
    for (int i = 0; i < 16; i++) begin
      check("scan_seg", sg[i], (ds[i] == 2'b01) ? 7'h6D : (BLANK ? 7'h00 : 7'h3F));
    end

    // Enable hold delays the tick by exactly the held cycles.
    do_reset();
    up = 1'b1;
    run_en(5);
    repeat (5) step();
    run_en(4);
    read_expect("hold00", 0);
    run_en(1);
    read_expect("hold01", 1);
    check("hold_nowrap", wrap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
